// File: rtl/alu_defs.sv
// Shared opcode and CLFZN flag definitions for the ALU operand-fetch stage and its neighbours.
package alu_defs;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_EXT   = 4'b1010;

  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  // Immediate forms replace Rsrc with the low instruction byte.
  function automatic logic is_imm_op(input logic [3:0] opcode);
    is_imm_op = (opcode == OP_ADDI) || (opcode == OP_ADDUI) || (opcode == OP_ADDCI);
  endfunction

  function automatic logic is_signed_imm(input logic [3:0] opcode);
    is_signed_imm = (opcode == OP_ADDI) || (opcode == OP_ADDCI);
  endfunction

endpackage

// File: rtl/alu_operand_fetch_if.sv
// Instruction-in / operation-out handshake bundle of the operand-fetch stage.
interface alu_operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        opcode;
  logic [3:0]        opext;
  logic [ADDR_W-1:0] dest;

  modport master (
    output instr_valid, instr, op_ready,
    input  instr_ready, op_valid, A, B, opcode, opext, dest
  );

  modport slave (
    input  instr_valid, instr, op_ready,
    output instr_ready, op_valid, A, B, opcode, opext, dest
  );

endinterface

// File: rtl/alu_operand_fetch_reg_file.sv
// General register file: two asynchronous read ports, one synchronous write port, cleared on reset.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // R0 is an ordinary register here; nothing is hardwired to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the 16-bit ALU; also owns register write-back and the CLFZN status register.
module alu_operand_fetch
  import alu_defs::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_operand_fetch_if.slave  bus,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flags_en,
  input  logic [4:0]          flags_in,
  output logic [4:0]          psr
);

  logic [ADDR_W-1:0] ra_idx;
  logic [ADDR_W-1:0] rb_idx;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] b_next;
  logic [3:0]        op_in;
  logic [7:0]        imm8;
  logic              accept;

  assign op_in  = bus.instr[15:12];
  assign ra_idx = bus.instr[11:8];
  assign rb_idx = bus.instr[3:0];
  assign imm8   = bus.instr[7:0];

  reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (ra_idx),
    .rd_data_a (rf_a),
    .rd_addr_b (rb_idx),
    .rd_data_b (rf_b)
  );

  // A write landing in the accept cycle must win over the stale register contents.
  always_comb begin
    a_next = rf_a;
    reg_b  = rf_b;
    b_next = '0;
    if (wb_en && (wb_addr == ra_idx)) begin
      a_next = wb_data;
    end
    if (wb_en && (wb_addr == rb_idx)) begin
      reg_b = wb_data;
    end
    if (is_imm_op(op_in)) begin
      if (is_signed_imm(op_in)) begin
        b_next = {{(DATA_W-8){imm8[7]}}, imm8};
      end else begin
        b_next = {{(DATA_W-8){1'b0}}, imm8};
      end
    end else begin
      b_next = reg_b;
    end
  end

  assign bus.instr_ready = !bus.op_valid || bus.op_ready;
  assign accept          = bus.instr_valid && bus.instr_ready;

  // Single-entry output register; fields only change on accept so a stalled op stays bit-stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.op_valid <= 1'b0;
      bus.A        <= '0;
      bus.B        <= '0;
      bus.opcode   <= '0;
      bus.opext    <= '0;
      bus.dest     <= '0;
    end else if (accept) begin
      bus.op_valid <= 1'b1;
      bus.A        <= a_next;
      bus.B        <= b_next;
      bus.opcode   <= op_in;
      bus.opext    <= bus.instr[7:4];
      bus.dest     <= ra_idx;
    end else if (bus.op_ready) begin
      bus.op_valid <= 1'b0;
    end
  end

  // psr[FLG_C] is the carry consumed by the ADDC family downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr <= '0;
    end else if (flags_en) begin
      psr <= flags_in;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomized and directed bench for alu_operand_fetch against a register-array reference model.
module tb_alu_operand_fetch;

  logic        clk;
  logic        reset;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flags_en;
  logic [4:0]  flags_in;
  logic [4:0]  psr;

  int total_checks;
  int bad_checks;

  logic [15:0] m_regs [16];
  logic        m_valid;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [3:0]  m_op;
  logic [3:0]  m_ext;
  logic [3:0]  m_dest;
  logic [4:0]  m_psr;

  alu_operand_fetch_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  alu_operand_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flags_en (flags_en),
    .flags_in (flags_in),
    .psr      (psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_valid = 1'b0;
    m_a = 16'h0;
    m_b = 16'h0;
    m_op = 4'h0;
    m_ext = 4'h0;
    m_dest = 4'h0;
    m_psr = 5'h0;
  endtask

  task automatic checkAll(input string pfx);
    checkOutput({pfx, "_op_valid"}, 32'(bus.op_valid), 32'(m_valid));
    checkOutput({pfx, "_A"}, 32'(bus.A), 32'(m_a));
    checkOutput({pfx, "_B"}, 32'(bus.B), 32'(m_b));
    checkOutput({pfx, "_opcode"}, 32'(bus.opcode), 32'(m_op));
    checkOutput({pfx, "_opext"}, 32'(bus.opext), 32'(m_ext));
    checkOutput({pfx, "_dest"}, 32'(bus.dest), 32'(m_dest));
    checkOutput({pfx, "_psr"}, 32'(psr), 32'(m_psr));
  endtask

  // Drive one cycle of inputs from a negedge, advance the model at the posedge, compare just after it.
  task automatic applyStimulus(input logic iv, input logic [15:0] ins, input logic ordy,
                               input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                               input logic fen, input logic [4:0] fin);
    logic        acc;
    logic [15:0] src_a;
    logic [15:0] src_b;
    int          imm;
    bus.instr_valid = iv;
    bus.instr       = ins;
    bus.op_ready    = ordy;
    wb_en           = wen;
    wb_addr         = wa;
    wb_data         = wd;
    flags_en        = fen;
    flags_in        = fin;
    #1;
    checkOutput("instr_ready", 32'(bus.instr_ready), 32'(!m_valid || ordy));
    acc = iv && (!m_valid || ordy);
    @(posedge clk);
    if (acc) begin
      src_a = (wen && wa == ins[11:8]) ? wd : m_regs[ins[11:8]];
      src_b = (wen && wa == ins[3:0]) ? wd : m_regs[ins[3:0]];
      imm = int'(ins[7:0]);
      case (ins[15:12])
        4'h5, 4'h7: begin
          if (imm > 127) imm = imm - 256;
          m_b = 16'(imm);
        end
        4'h6: m_b = 16'(imm);
        default: m_b = src_b;
      endcase
      m_valid = 1'b1;
      m_a     = src_a;
      m_op    = ins[15:12];
      m_ext   = ins[7:4];
      m_dest  = ins[11:8];
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (wen) m_regs[wa] = wd;
    if (fen) m_psr = fin;
    #1;
    checkAll("cyc");
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  op_tbl [6];
    logic [15:0] ins;
    logic [3:0]  wa;
    total_checks = 0;
    bad_checks   = 0;
    op_tbl[0] = 4'h0; op_tbl[1] = 4'h5; op_tbl[2] = 4'h6;
    op_tbl[3] = 4'h7; op_tbl[4] = 4'hA; op_tbl[5] = 4'h3;

    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    bus.op_ready = 1'b0;
    wb_en = 1'b0;
    wb_addr = 4'h0;
    wb_data = 16'h0;
    flags_en = 1'b0;
    flags_in = 5'h0;
    clearModel();
    #1;
    checkAll("reset");
    checkOutput("reset_instr_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 16'h0, 1, 1, 4'd3, 16'h1234, 0, 5'h0);
    applyStimulus(0, 16'h0, 1, 1, 4'd4, 16'h0001, 0, 5'h0);
    applyStimulus(1, 16'h0354, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    checkOutput("add_A", 32'(bus.A), 32'h1234);
    checkOutput("add_B", 32'(bus.B), 32'h0001);
    checkOutput("add_opext", 32'(bus.opext), 32'h5);
    checkOutput("add_dest", 32'(bus.dest), 32'h3);

    applyStimulus(1, 16'h52F0, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    checkOutput("addi_B", 32'(bus.B), 32'hFFF0);
    applyStimulus(1, 16'h62F0, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    checkOutput("addui_B", 32'(bus.B), 32'h00F0);

    applyStimulus(1, 16'h0354, 1, 1, 4'd4, 16'hBEEF, 0, 5'h0);
    checkOutput("bypass_B", 32'(bus.B), 32'hBEEF);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'h7A12 + 16'(i), 0, 1, 4'd4, 16'h5555, 0, 5'h0);
      checkOutput("stall_B", 32'(bus.B), 32'hBEEF);
    end
    applyStimulus(1, 16'h0A43, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    applyStimulus(1, 16'h5301, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    checkOutput("b2b_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("b2b_B", 32'(bus.B), 32'h0001);

    applyStimulus(0, 16'h0, 1, 0, 4'd0, 16'h0, 1, 5'b10010);
    checkOutput("psr_load", 32'(psr), 32'h12);
    applyStimulus(0, 16'h0, 1, 0, 4'd0, 16'h0, 0, 5'b01101);
    checkOutput("psr_hold", 32'(psr), 32'h12);

    applyStimulus(1, 16'h0354, 0, 0, 4'd0, 16'h0, 0, 5'h0);
    #2;
    reset = 1'b1;
    #1;
    clearModel();
    checkAll("midreset");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 16'h0333, 1, 0, 4'd0, 16'h0, 0, 5'h0);
    checkOutput("r3_cleared", 32'(bus.A), 32'h0);

    for (int n = 0; n < 400; n++) begin
      ins = {op_tbl[$urandom_range(0, 5)], 12'($urandom)};
      wa = 4'($urandom);
      if ($urandom_range(0, 3) == 0) wa = ins[3:0];
      else if ($urandom_range(0, 3) == 0) wa = ins[11:8];
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                    1'($urandom), wa, 16'($urandom), $urandom_range(0, 3) == 0, 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
